// File: rtl/serial_adder_ctrl_if.sv
// Start/busy/done handshake and operand/result bus for serial_adder_ctrl.
interface serial_adder_ctrl_if #(
    parameter int unsigned N = 4
);
    logic         start;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         c_in;
    logic         busy;
    logic         done;
    logic [N-1:0] sum;
    logic         c_out;
    logic         ovf;

    modport master (
        output start, a, b, c_in,
        input  busy, done, sum, c_out, ovf
    );

    modport slave (
        input  start, a, b, c_in,
        output busy, done, sum, c_out, ovf
    );
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial N-bit adder controller: one mux-built full adder, one bit per clock, LSB first.
// Optional macro SERIAL_ADDER_OVF_EN enables the registered signed-overflow flag.
module serial_adder_ctrl #(
    parameter int unsigned N = 4
) (
    input logic               clock,
    input logic               reset,
    serial_adder_ctrl_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(N + 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [N-1:0]     a_q, a_d;
    logic [N-1:0]     b_q, b_d;
    logic [N-1:0]     acc_q, acc_d;
    logic [N-1:0]     sum_q, sum_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             c_out_q, c_out_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [1:0]       fa_sel;
    logic             fa_s;
    logic             fa_c;

    function automatic logic mux4(input logic [1:0] sel, input logic [3:0] d);
        return d[sel];
    endfunction

    // Full adder from two 4:1 muxes selected by the operand bits, carry as data.
    assign fa_sel = {a_q[0], b_q[0]};
    assign fa_s   = mux4(fa_sel, {carry_q, ~carry_q, ~carry_q, carry_q});
    assign fa_c   = mux4(fa_sel, {1'b1, carry_q, carry_q, 1'b0});

`ifdef SERIAL_ADDER_OVF_EN
    logic ovf_q, ovf_d;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            c_out_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            c_out_q <= c_out_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        c_out_d = c_out_q;
`ifdef SERIAL_ADDER_OVF_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    carry_d = bus.c_in;
                    cnt_d   = CNT_W'(N);
                    acc_d   = '0;
                    state_d = SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                a_d     = {1'b0, a_q[N-1:1]};
                b_d     = {1'b0, b_q[N-1:1]};
                acc_d   = {fa_s, acc_q[N-1:1]};
                carry_d = fa_c;
                cnt_d   = cnt_q - CNT_W'(1);
                // Last bit: publish the result; carry_q is the carry into the MSB here.
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                    sum_d   = {fa_s, acc_q[N-1:1]};
                    c_out_d = fa_c;
`ifdef SERIAL_ADDER_OVF_EN
                    ovf_d   = carry_q ^ fa_c;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == SHIFT);
        done_d = (state_d == DONE);
    end

    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.sum   = sum_q;
    assign bus.c_out = c_out_q;
`ifdef SERIAL_ADDER_OVF_EN
    assign bus.ovf   = ovf_q;
`else
    assign bus.ovf   = 1'b0;
`endif
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl: directed vectors, timing checks and an N=4 sweep.
module tb_serial_adder_ctrl;
    localparam int unsigned N = 4;

`ifdef SERIAL_ADDER_OVF_EN
    localparam bit OVF_ON = 1'b1;
`else
    localparam bit OVF_ON = 1'b0;
`endif

    typedef struct packed {
        logic [N-1:0] sum;
        logic         c_out;
        logic         ovf;
    } res_t;

    logic clock;
    logic reset;
    int   checks;
    int   errors;
    res_t exp_q[$];

    serial_adder_ctrl_if #(.N(N)) bus ();

    serial_adder_ctrl #(.N(N)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops one expected result for every done pulse.
    always @(negedge clock) begin
        if (!reset) begin
            if (bus.busy && bus.done) check("busy_and_done", 32'd1, 32'd0);
            if (bus.done) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    res_t e;
                    e = exp_q.pop_front();
                    check("sum",   32'(bus.sum),   32'(e.sum));
                    check("c_out", 32'(bus.c_out), 32'(e.c_out));
                    check("ovf",   32'(bus.ovf),   32'(e.ovf));
                end
            end
        end
    end

    // Called at a negedge with the DUT in IDLE or DONE; returns at the negedge showing done.
    task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic cin,
                          input logic [N-1:0] e_sum, input logic e_cout, input logic e_ovf,
                          input bit keep_start, input bit inject);
        res_t e;
        bus.a = a; bus.b = b; bus.c_in = cin; bus.start = 1'b1;
        e.sum = e_sum; e.c_out = e_cout; e.ovf = e_ovf & OVF_ON;
        exp_q.push_back(e);
        for (int k = 1; k <= int'(N); k++) begin
            @(negedge clock);
            if (k == 1) bus.start = keep_start;
            if (inject && k == 2) begin
                bus.start = 1'b1; bus.a = 4'b1010; bus.b = 4'b0110; bus.c_in = 1'b1;
            end
            if (inject && k == 3) bus.start = keep_start;
            check("busy_in_shift", 32'(bus.busy), 32'd1);
            check("no_done_in_shift", 32'(bus.done), 32'd0);
        end
        @(negedge clock);
        check("done_latency", 32'(bus.done), 32'd1);
        check("busy_low_at_done", 32'(bus.busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        logic [N:0]   full;
        logic [N-1:0] low;
        logic         e_ovf;
        checks = 0;
        errors = 0;
        reset = 1'b1;
        bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.c_in = 1'b0;
        repeat (2) @(negedge clock);
        check("rst_busy",  32'(bus.busy),  32'd0);
        check("rst_done",  32'(bus.done),  32'd0);
        check("rst_sum",   32'(bus.sum),   32'd0);
        check("rst_c_out", 32'(bus.c_out), 32'd0);
        check("rst_ovf",   32'(bus.ovf),   32'd0);
        reset = 1'b0;
        @(negedge clock);

        // Basic vectors
        run_op(4'b0101, 4'b0011, 1'b0, 4'b1000, 1'b0, 1'b1, 1'b0, 1'b0);
        @(negedge clock);
        check("idle_after_done", 32'(bus.done), 32'd0);
        check("sum_held", 32'(bus.sum), 32'h8);
        run_op(4'b1111, 4'b0001, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clock);
        run_op(4'b0000, 4'b0000, 1'b1, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clock);

        // Start during SHIFT is ignored
        run_op(4'b0101, 4'b0011, 1'b0, 4'b1000, 1'b0, 1'b1, 1'b0, 1'b1);
        repeat (N + 2) begin
            @(negedge clock);
            check("no_extra_done", 32'(bus.done), 32'd0);
        end

        // Reset in the 3rd SHIFT cycle aborts and clears the held result
        bus.a = 4'b0110; bus.b = 4'b0001; bus.c_in = 1'b0; bus.start = 1'b1;
        @(negedge clock);
        bus.start = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        #1;
        check("abort_busy",  32'(bus.busy),  32'd0);
        check("abort_done",  32'(bus.done),  32'd0);
        check("abort_sum",   32'(bus.sum),   32'd0);
        check("abort_c_out", 32'(bus.c_out), 32'd0);
        check("abort_ovf",   32'(bus.ovf),   32'd0);
        @(negedge clock);
        reset = 1'b0;
        repeat (N + 2) begin
            @(negedge clock);
            check("abort_no_done", 32'(bus.done), 32'd0);
            check("abort_idle",    32'(bus.busy), 32'd0);
        end
        run_op(4'b0110, 4'b0001, 1'b0, 4'b0111, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clock);

        // Back-to-back with start held high
        run_op(4'b0001, 4'b0001, 1'b0, 4'b0010, 1'b0, 1'b0, 1'b1, 1'b0);
        run_op(4'b0010, 4'b0010, 1'b0, 4'b0100, 1'b0, 1'b0, 1'b1, 1'b0);
        run_op(4'b0111, 4'b0111, 1'b1, 4'b1111, 1'b0, 1'b1, 1'b0, 1'b0);
        @(negedge clock);
        check("b2b_idle", 32'(bus.busy), 32'd0);

        // Exhaustive sweep
        for (int i = 0; i < 512; i++) begin
            logic [N-1:0] a;
            logic [N-1:0] b;
            logic         cin;
            a   = N'(i >> 5);
            b   = N'(i >> 1);
            cin = 1'(i);
            full  = (N+1)'(a) + (N+1)'(b) + (N+1)'(cin);
            low   = N'({1'b0, a[N-2:0]}) + N'({1'b0, b[N-2:0]}) + N'(cin);
            e_ovf = low[N-1] ^ full[N];
            run_op(a, b, cin, full[N-1:0], full[N], e_ovf, 1'b0, 1'b0);
            @(negedge clock);
        end

        repeat (3) @(negedge clock);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/serial_adder_ctrl.md
# serial_adder_ctrl

Bit-serial N-bit adder controller. It sequences a single 1-bit full adder built from 4-to-1 multiplexers over two N-bit operands, one bit per clock, LSB first. Operand and result shift registers, a carry flip-flop and a bit counter are held internally. It presents a start/busy/done handshake to the surrounding datapath and trades area for N cycles of latency.

## Interface
- N, default 4: operand width in bits, N ≥ 2.
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous reset, active-high.
- start  input  1  request to begin an addition; sampled only in IDLE or DONE.
- a  input  N  operand A; captured on the accepting edge.
- b  input  N  operand B; captured on the accepting edge.
- c_in  input  1  carry-in; captured on the accepting edge.
- busy  output  1  high while bits are being processed (SHIFT state).
- done  output  1  single-cycle pulse; the result is valid from this cycle onward.
- sum  output  N  result; held stable from done until the next accepted start.
- c_out  output  1  final carry; held with sum.
- ovf  output  1  signed overflow; see Configuration.

## Operation
- States: IDLE, SHIFT, DONE. Reset state is IDLE.
- IDLE, start=1:
  - load A_reg←a, B_reg←b, carry←c_in, cnt←N, clear sum_reg.
  - go to SHIFT.
- IDLE, start=0: remain in IDLE.
- SHIFT, each edge:
  - full adder inputs: A_reg[0], B_reg[0], carry; produces s and c.
  - A_reg and B_reg shift right by one, zero filled.
  - sum_reg←{s, sum_reg[N-1:1]}.
  - carry←c; cnt←cnt−1.
  - When cnt=1 before the edge, go to DONE. Exactly N SHIFT edges are taken.
- DONE:
  - done=1 for one cycle.
  - start=1: same action as IDLE with start=1; go to SHIFT. This gives back-to-back operation.
  - start=0: go to IDLE.
- sum, c_out and ovf are registers. They are updated only as SHIFT completes and are held through IDLE.
- start during SHIFT is ignored. It is not queued, and the operand inputs are don't-care.
- Arithmetic: {c_out, sum} = a + b + c_in, modulo 2^(N+1). No sign extension.
- cnt width: ceil(log2(N+1)) bits. cnt never wraps, because the state leaves SHIFT at 1.

## Timing
- Reset values: busy=0, done=0, sum=0, c_out=0, ovf=0, state=IDLE, counter and shift registers 0.
- Reset asserted mid-SHIFT aborts the operation at once. No done is produced, and the previous result is lost (it reads 0).
- Start accepted at edge E0:
  - busy=1 from E0 through E0+N.
  - done=1 in the cycle after edge E0+N.
  - Latency from start acceptance to done is N+1 cycles.
- The result is valid in the same cycle that done is high.
- busy and done are never high together.
- Back-to-back: start held high continuously gives one result every N+1 cycles.

## Configuration
- SERIAL_ADDER_OVF_EN defined:
  - an extra flip-flop captures the adder carry into bit N−1, i.e. the carry register value before the final SHIFT edge.
  - ovf = that captured carry XOR c_out, registered and updated with c_out.
- SERIAL_ADDER_OVF_EN undefined: the ovf port remains and is tied to 0. No extra flip-flop is present.

## Test plan
- N=4, a=0101, b=0011, c_in=0, one start pulse → busy for 4 cycles, done 5 cycles after acceptance, sum=1000, c_out=0; ovf=1 with the macro, 0 without.
- a=1111, b=0001, c_in=0 → sum=0000, c_out=1, ovf=0; then a=0000, b=0000, c_in=1 → sum=0001, c_out=0.
- Start pulsed again in the 2nd SHIFT cycle with different operands → ignored, first result correct, only one done pulse.
- Reset asserted in the 3rd SHIFT cycle → all outputs 0 immediately, state IDLE, no done; a fresh start then completes normally.
- Start held high for 3 operations (0001+0001, 0010+0010, 0111+0111 with c_in=1) → done every 5 cycles, sums 0010, 0100, 1111 with c_out 0, 0, 0.
- Exhaustive N=4 sweep over all a, b and c_in → {c_out, sum} matches a+b+c_in for all 512 cases.
